// File: rtl/linear_pkg.sv
// Shared types and defaults for the linear-unit arbiter: FSM state encoding,
// parameter defaults and the select-width helper.
package linear_pkg;

  localparam int LIN_NUM_REQ        = 3;
  localparam int LIN_TIMEOUT_CYCLES = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } lin_state_e;

  // A single requester still needs a 1-bit select so ports stay legal.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: scans requests starting at ptr+1 (mod NUM_REQ)
// and returns the first hit as both one-hot and binary index.
module rr_pick
  import linear_pkg::*;
#(
  parameter  int NUM_REQ = LIN_NUM_REQ,
  localparam int SW      = sel_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [SW-1:0]      idx_o,
  output logic               valid_o
);

  logic [SW-1:0] cand;
  logic          found;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    cand     = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = SW'((int'(ptr_i) + 1 + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/linear_arbiter.sv
// Round-robin owner arbiter for one shared linear unit (IDLE/START/WAIT/ACK).
// Optional WAIT timeout with err flag: define LINEAR_ARBITER_TIMEOUT_EN.
module linear_arbiter
  import linear_pkg::*;
#(
  parameter  int NUM_REQ        = LIN_NUM_REQ,
  parameter  int TIMEOUT_CYCLES = LIN_TIMEOUT_CYCLES,
  localparam int SW             = sel_w(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SW-1:0]      sel_o,
  output logic               lin_start_o,
  input  logic               lin_done_i,
  output logic [NUM_REQ-1:0] ack_o,
  output logic               busy_o,
  output logic               err_o
);

  if (NUM_REQ < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("linear_arbiter: NUM_REQ and TIMEOUT_CYCLES must be >= 1");
  end

  lin_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] ack_q;
  logic [SW-1:0]      sel_q;
  logic [SW-1:0]      ptr_q;
  logic               lin_start_q;
  logic               busy_q;

  logic [NUM_REQ-1:0] pick_oh;
  logic [SW-1:0]      pick_idx;
  logic               pick_vld;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .valid_o  (pick_vld)
  );

`ifdef LINEAR_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt_q;
  logic [CW-1:0] tmo_cnt_d;
  logic          tmo_hit;
  logic          err_q;

  assign tmo_hit = (state_q == ST_WAIT) && !lin_done_i && (tmo_cnt_q == TMO_LAST);

  // Counter only advances while waiting; any exit from WAIT leaves it at zero.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_WAIT && !lin_done_i && !tmo_hit) tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      sel_q       <= '0;
      ack_q       <= '0;
      lin_start_q <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= SW'(NUM_REQ - 1);
`ifdef LINEAR_ARBITER_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      lin_start_q <= 1'b0;
      ack_q       <= '0;
`ifdef LINEAR_ARBITER_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q     <= ST_START;
            grant_q     <= pick_oh;
            sel_q       <= pick_idx;
            lin_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        // A done pulse coincident with lin_start belongs to nobody; drop it.
        ST_START: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (lin_done_i) begin
            state_q <= ST_ACK;
            ack_q   <= grant_q;
          end
`ifdef LINEAR_ARBITER_TIMEOUT_EN
          else if (tmo_hit) begin
            state_q <= ST_ACK;
            ack_q   <= grant_q;
            err_q   <= 1'b1;
          end
`endif
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= sel_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign sel_o       = sel_q;
  assign lin_start_o = lin_start_q;
  assign ack_o       = ack_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_linear_arbiter.sv
// Directed bench for linear_arbiter (NUM_REQ=3, TIMEOUT_CYCLES=16); expected
// output vectors are {grant, sel, lin_start, ack, busy, err}.
module tb_linear_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic       lin_done;
  logic [2:0] grant;
  logic [1:0] sel;
  logic       lin_start;
  logic [2:0] ack;
  logic       busy;
  logic       err;

  int n_chk  = 0;
  int n_pass = 0;
  logic [10:0] exp_v;

  always #5 clk = ~clk;

  linear_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(16)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_i       (req),
    .grant_o     (grant),
    .sel_o       (sel),
    .lin_start_o (lin_start),
    .lin_done_i  (lin_done),
    .ack_o       (ack),
    .busy_o      (busy),
    .err_o       (err)
  );

  wire [10:0] outs = {grant, sel, lin_start, ack, busy, err};

  function automatic logic [10:0] pk(input logic [2:0] g, input logic [1:0] s, input logic ls,
                                     input logic [2:0] a, input logic b, input logic e);
    return {g, s, ls, a, b, e};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req = 3'b000; lin_done = 1'b0;
    tick(2);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 3'b111; lin_done = 1'b1;
    tick(2);
    exp_v = pk(3'b000, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL reset_outs: got %b exp %b", outs, exp_v); else n_pass++;
    reset = 1'b1; req = 3'b000; lin_done = 1'b0;
    tick();
    n_chk++;
    if (outs !== exp_v) $display("FAIL idle_after_reset: got %b exp %b", outs, exp_v); else n_pass++;
  endtask

  task automatic test_single();
    req = 3'b001;                                   // cycle 0
    tick();                                         // cycle 1
    exp_v = pk(3'b001, 2'd0, 1'b1, 3'b000, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL single_start: got %b exp %b", outs, exp_v); else n_pass++;
    tick();
    exp_v = pk(3'b001, 2'd0, 1'b0, 3'b000, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL single_wait: got %b exp %b", outs, exp_v); else n_pass++;
    tick(8);                                        // cycle 10
    lin_done = 1'b1;
    tick();                                         // cycle 11
    lin_done = 1'b0; req = 3'b000;
    exp_v = pk(3'b001, 2'd0, 1'b0, 3'b001, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL single_ack: got %b exp %b", outs, exp_v); else n_pass++;
    tick();                                         // cycle 12
    exp_v = pk(3'b000, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL single_idle: got %b exp %b", outs, exp_v); else n_pass++;
  endtask

  task automatic test_fairness();
    int ord [4] = '{0, 1, 2, 0};
    logic [1:0] s;
    logic [2:0] g;
    do_reset();
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      s = 2'(ord[k]);
      g = 3'b001 << s;
      tick();
      exp_v = pk(g, s, 1'b1, 3'b000, 1'b1, 1'b0); n_chk++;
      if (outs !== exp_v) $display("FAIL fair_grant%0d: got %b exp %b", k, outs, exp_v); else n_pass++;
      tick(5);
      lin_done = 1'b1;
      tick();
      lin_done = 1'b0;
      exp_v = pk(g, s, 1'b0, g, 1'b1, 1'b0); n_chk++;
      if (outs !== exp_v) $display("FAIL fair_ack%0d: got %b exp %b", k, outs, exp_v); else n_pass++;
      tick();
      exp_v = pk(3'b000, s, 1'b0, 3'b000, 1'b0, 1'b0); n_chk++;
      if (outs !== exp_v) $display("FAIL fair_gap%0d: got %b exp %b", k, outs, exp_v); else n_pass++;
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_owner_drop();
    do_reset();
    req = 3'b001;
    tick(2);                                        // in WAIT
    req = 3'b010;                                   // owner drops, other requester rises
    tick(3);
    exp_v = pk(3'b001, 2'd0, 1'b0, 3'b000, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL drop_hold: got %b exp %b", outs, exp_v); else n_pass++;
    lin_done = 1'b1;
    tick();
    lin_done = 1'b0;
    exp_v = pk(3'b001, 2'd0, 1'b0, 3'b001, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL drop_ack: got %b exp %b", outs, exp_v); else n_pass++;
    tick();
    exp_v = pk(3'b000, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL drop_idle: got %b exp %b", outs, exp_v); else n_pass++;
    tick();
    exp_v = pk(3'b010, 2'd1, 1'b1, 3'b000, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL drop_next: got %b exp %b", outs, exp_v); else n_pass++;
    tick();
    lin_done = 1'b1;
    tick();
    lin_done = 1'b0; req = 3'b000;
    exp_v = pk(3'b010, 2'd1, 1'b0, 3'b010, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL drop_next_ack: got %b exp %b", outs, exp_v); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b010;                                   // ptr ends at 1 after this op
    tick(2);
    lin_done = 1'b1;
    tick();
    lin_done = 1'b0; req = 3'b000;
    tick();
    req = 3'b100;
    tick(3);                                        // owner 2 in WAIT
    reset = 1'b0;
    tick();
    exp_v = pk(3'b000, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL rstmid_outs: got %b exp %b", outs, exp_v); else n_pass++;
    reset = 1'b1; req = 3'b000; lin_done = 1'b1;   // late done from abandoned op
    tick();
    lin_done = 1'b0;
    n_chk++;
    if (outs !== exp_v) $display("FAIL rstmid_late_done: got %b exp %b", outs, exp_v); else n_pass++;
    tick();
    n_chk++;
    if (outs !== exp_v) $display("FAIL rstmid_no_ack: got %b exp %b", outs, exp_v); else n_pass++;
    req = 3'b110;                                   // ptr=2 -> 1 wins; stale ptr=1 would pick 2
    tick();
    exp_v = pk(3'b010, 2'd1, 1'b1, 3'b000, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL rstmid_ptr: got %b exp %b", outs, exp_v); else n_pass++;
    tick();
    lin_done = 1'b1;
    tick();
    lin_done = 1'b0; req = 3'b000;
    tick();
    req = 3'b100;
    tick();
    exp_v = pk(3'b100, 2'd2, 1'b1, 3'b000, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL rstmid_req2: got %b exp %b", outs, exp_v); else n_pass++;
    tick();
    lin_done = 1'b1;
    tick();
    lin_done = 1'b0; req = 3'b000;
    tick();
  endtask

  task automatic test_start_done();
    do_reset();
    req = 3'b001;
    tick();                                         // START cycle
    lin_done = 1'b1;
    tick();
    lin_done = 1'b0;
    exp_v = pk(3'b001, 2'd0, 1'b0, 3'b000, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL sd_ignored: got %b exp %b", outs, exp_v); else n_pass++;
    tick(3);
    n_chk++;
    if (outs !== exp_v) $display("FAIL sd_still_wait: got %b exp %b", outs, exp_v); else n_pass++;
    lin_done = 1'b1;
    tick();
    lin_done = 1'b0; req = 3'b000;
    exp_v = pk(3'b001, 2'd0, 1'b0, 3'b001, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL sd_ack: got %b exp %b", outs, exp_v); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 3'b001;
    tick(2);                                        // first WAIT cycle
    req = 3'b000;
`ifdef LINEAR_ARBITER_TIMEOUT_EN
    tick(15);
    exp_v = pk(3'b001, 2'd0, 1'b0, 3'b000, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL tmo_before: got %b exp %b", outs, exp_v); else n_pass++;
    tick();
    exp_v = pk(3'b001, 2'd0, 1'b0, 3'b001, 1'b1, 1'b1); n_chk++;
    if (outs !== exp_v) $display("FAIL tmo_fire: got %b exp %b", outs, exp_v); else n_pass++;
    tick();
    exp_v = pk(3'b000, 2'd0, 1'b0, 3'b000, 1'b0, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL tmo_clear: got %b exp %b", outs, exp_v); else n_pass++;
`else
    tick(40);
    exp_v = pk(3'b001, 2'd0, 1'b0, 3'b000, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL tmo_off_wait: got %b exp %b", outs, exp_v); else n_pass++;
    lin_done = 1'b1;
    tick();
    lin_done = 1'b0;
    exp_v = pk(3'b001, 2'd0, 1'b0, 3'b001, 1'b1, 1'b0); n_chk++;
    if (outs !== exp_v) $display("FAIL tmo_off_ack: got %b exp %b", outs, exp_v); else n_pass++;
    tick();
`endif
  endtask

  initial begin
    reset = 1'b0; req = 3'b000; lin_done = 1'b0;
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_owner_drop();
    test_reset_mid();
    test_start_done();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/linear_arbiter.md
LINEAR_ARBITER -- requirements
Module: linear_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters sharing one linear unit (e.g. Q/K/V projections).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles to wait for lin_done (used only under REQ-026).
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 req  input  NUM_REQ  per-requester request; held high until that requester's ack.
REQ-006 grant  output  NUM_REQ  one-hot owner of the linear unit; all zero when idle.
REQ-007 sel  output  $clog2(NUM_REQ)  binary index of the granted requester; drives operand/weight/bias muxes.
REQ-008 lin_start  output  1  one-cycle start pulse to the shared linear unit.
REQ-009 lin_done  input  1  completion pulse from the shared linear unit.
REQ-010 ack  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 err  output  1  timeout flag, pulsed together with ack.

Function
REQ-013 FSM states IDLE, START, WAIT, ACK; encoding from the shared package.
REQ-014 IDLE: if any req bit set, select the winner by round-robin starting at ptr+1 (mod NUM_REQ), register grant/sel, go to START; else stay.
REQ-015 START: lin_start=1 for exactly this cycle; grant/sel stable; go to WAIT.
REQ-016 lin_done is ignored in IDLE and START.
REQ-017 WAIT: lin_start=0; on lin_done=1 go to ACK; otherwise stay.
REQ-018 ACK: ack[sel]=1 for this cycle only; grant/sel still held; ptr<=sel; go to IDLE.
REQ-019 grant clears to zero on entry to IDLE; sel holds its last value.
REQ-020 Latency: req sampled in IDLE at cycle N -> grant and lin_start at N+1; lin_done at cycle D -> ack at D+1; minimum one IDLE cycle between operations.
REQ-021 req deasserted by the owner while granted: operation still completes and ack is still issued; non-owner req changes never alter grant mid-operation.
REQ-022 Simultaneous requests: exactly one winner; a continuously asserted requester waits at most NUM_REQ-1 operations.
REQ-023 ptr wraps NUM_REQ-1 -> 0.

Reset
REQ-024 While reset=0 on a clock edge: state<=IDLE, grant=0, sel=0, lin_start=0, ack=0, busy=0, err=0, ptr<=NUM_REQ-1 (requester 0 wins first); timeout counter cleared.
REQ-025 Reset mid-operation abandons the operation with no ack; a late lin_done after reset release is ignored per REQ-016/REQ-014.

Configuration
REQ-026 With LINEAR_ARBITER_TIMEOUT_EN defined: a counter runs in WAIT; if TIMEOUT_CYCLES elapse without lin_done, go to ACK with ack[sel]=1 and err=1 for that cycle; counter clears on leaving WAIT.
REQ-027 Without LINEAR_ARBITER_TIMEOUT_EN: no counter is synthesised, WAIT waits indefinitely, and err is tied to 0.

Structure
REQ-028 Package linear_pkg holds the FSM state typedef and the NUM_REQ/TIMEOUT_CYCLES defaults.
REQ-029 The round-robin winner pick (req, ptr -> one-hot, index) is a combinational sub-module rr_pick instantiated once.

Verification
REQ-030 Single request: req=3'b001 at cycle 0 -> grant=001, sel=0, lin_start at cycle 1; lin_done at cycle 10 -> ack=001 at cycle 11; grant=000 at cycle 12.
REQ-031 Fairness: req=3'b111 held with lin_done 5 cycles after each lin_start -> grant order 0,1,2,0; each ack is a single cycle.
REQ-032 Owner drops req in WAIT: operation completes, ack still pulses; a new req=3'b010 is granted next.
REQ-033 Reset=0 asserted in WAIT: all outputs 0 on the next edge; lin_done after release produces no ack; next req=3'b100 is granted, with ptr back at 2.
REQ-034 Timeout (macro on, TIMEOUT_CYCLES=16): lin_done never arrives -> ack and err pulse together 16 cycles after entering WAIT; macro off -> busy stays 1 and err stays 0.
REQ-035 lin_done pulsed in the same cycle as lin_start -> ignored; FSM remains in WAIT until the next lin_done.
